// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external WIDTHxWIDTH multiplier among 4 requesters
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req[3:0]              request lines, held until the matching gnt bit pulses
//   op_a, op_b            per-requester operands, requester i uses slice [i*WIDTH +: WIDTH]
//   gnt[3:0]              registered one-hot grant, single-cycle pulse
//   mul_a, mul_b, mul_p   operands to and product from the shared multiplier
//   res_valid/res_ready   result handshake; res_id names the owner, res_data holds the product
//   busy                  registered, high whenever a transaction is in progress
module mult_share_arbiter #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   op_a,
    input  logic [4*WIDTH-1:0]   op_b,
    output logic [3:0]           gnt,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 res_valid,
    output logic [1:0]           res_id,
    output logic [2*WIDTH-1:0]   res_data,
    input  logic                 res_ready,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
    state_t state, state_n;
    logic [1:0] rr_ptr, ptr_n, win, res_id_n;
    logic [3:0] cnt, cnt_n, gnt_n;
    logic [WIDTH-1:0] mul_a_n, mul_b_n;
    logic [2*WIDTH-1:0] res_data_n;
    logic res_valid_n, found;
    // Scan downward so the requester closest to rr_ptr (offset 0 first) wins.
    always_comb begin
        found = 1'b0;
        win = rr_ptr;
        for (int i = 3; i >= 0; i--)
            if (req[rr_ptr + 2'(i)]) begin
                found = 1'b1;
                win = rr_ptr + 2'(i);
            end
    end
    always_comb begin
        state_n = state;
        ptr_n = rr_ptr;
        cnt_n = cnt;
        gnt_n = '0;
        mul_a_n = mul_a;
        mul_b_n = mul_b;
        res_valid_n = res_valid;
        res_id_n = res_id;
        res_data_n = res_data;
        unique case (state)
            IDLE: if (found) begin
                gnt_n = 4'b0001 << win;
                mul_a_n = op_a[int'(win)*WIDTH +: WIDTH];
                mul_b_n = op_b[int'(win)*WIDTH +: WIDTH];
                res_id_n = win;
                ptr_n = win + 2'd1;
                cnt_n = 4'(SETTLE);
                state_n = CALC;
            end
            // The counter is loaded with SETTLE on the grant edge, so sampling at 1
            // places res_valid exactly SETTLE edges after gnt rises.
            CALC: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    res_data_n = mul_p;
                    res_valid_n = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: if (res_ready) begin
                res_valid_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            gnt <= '0;
            mul_a <= '0;
            mul_b <= '0;
            res_valid <= 1'b0;
            res_id <= '0;
            res_data <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            rr_ptr <= ptr_n;
            cnt <= cnt_n;
            gnt <= gnt_n;
            mul_a <= mul_a_n;
            mul_b <= mul_b_n;
            res_valid <= res_valid_n;
            res_id <= res_id_n;
            res_data <= res_data_n;
            busy <= (state_n != IDLE);
        end
    end
endmodule
